// File: rtl/pipeline_mem_wb.sv
// MEM/WB pipeline register built as a two-entry skid buffer. in_ready is registered
// and depends only on skid occupancy; the main entry feeds WB and the forwarding taps.
module pipeline_mem_wb #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] DM,
  input  logic [DATA_W-1:0] ALU_ea,
  input  logic [RA_W-1:0]   ra,
  input  logic              wb_wb_sel,
  input  logic              wb_data_sel,
  input  logic              wb_reg_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] DM_out,
  output logic [DATA_W-1:0] ALU_ea_out,
  output logic [RA_W-1:0]   ra_out,
  output logic              wb_wb_sel_out,
  output logic              wb_data_sel_out,
  output logic              wb_reg_en_out,
  output logic              fwd_hit,
  output logic [RA_W-1:0]   fwd_ra,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occupancy
);

  function automatic logic [DATA_W-1:0] pick_wb_data(
    input logic              data_sel,
    input logic [DATA_W-1:0] dm_val,
    input logic [DATA_W-1:0] alu_val
  );
    return data_sel ? dm_val : alu_val;
  endfunction

  function automatic logic [1:0] count_valid(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Skid entry (p0): holds the entry accepted while the main entry is stalled
  logic              vld_p0;
  logic [DATA_W-1:0] dm_p0;
  logic [DATA_W-1:0] alu_p0;
  logic [RA_W-1:0]   ra_p0;
  logic              wb_sel_p0;
  logic              data_sel_p0;
  logic              reg_en_p0;

  // Main entry (p1): drives every output towards WB
  logic              vld_p1;
  logic [DATA_W-1:0] dm_p1;
  logic [DATA_W-1:0] alu_p1;
  logic [RA_W-1:0]   ra_p1;
  logic              wb_sel_p1;
  logic              data_sel_p1;
  logic              reg_en_p1;

  logic              in_ready_q;
  logic              accept;
  logic              drain;
  logic              load_m_in;
  logic              load_m_skid;
  logic              load_s;
  logic              vld_p0_nxt;
  logic              vld_p1_nxt;

  assign accept = in_valid & in_ready_q;
  assign drain  = vld_p1 & out_ready;

  always_comb begin
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    vld_p0_nxt  = vld_p0;
    vld_p1_nxt  = vld_p1;
    if (flush) begin
      vld_p0_nxt = 1'b0;
      vld_p1_nxt = 1'b0;
    end else if (vld_p0) begin
      // in_ready is low here, so no accept can compete with the skid refill
      if (drain) begin
        load_m_skid = 1'b1;
        vld_p0_nxt  = 1'b0;
      end
    end else if (!vld_p1 || drain) begin
      if (accept) begin
        load_m_in  = 1'b1;
        vld_p1_nxt = 1'b1;
      end else begin
        vld_p1_nxt = 1'b0;
      end
    end else if (accept) begin
      load_s     = 1'b1;
      vld_p0_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      vld_p0      <= 1'b0;
      dm_p0       <= '0;
      alu_p0      <= '0;
      ra_p0       <= '0;
      wb_sel_p0   <= 1'b0;
      data_sel_p0 <= 1'b0;
      reg_en_p0   <= 1'b0;
      vld_p1      <= 1'b0;
      dm_p1       <= '0;
      alu_p1      <= '0;
      ra_p1       <= '0;
      wb_sel_p1   <= 1'b0;
      data_sel_p1 <= 1'b0;
      reg_en_p1   <= 1'b0;
    end else begin
      vld_p0     <= vld_p0_nxt;
      vld_p1     <= vld_p1_nxt;
      in_ready_q <= ~vld_p0_nxt;
      if (load_s) begin
        dm_p0       <= DM;
        alu_p0      <= ALU_ea;
        ra_p0       <= ra;
        wb_sel_p0   <= wb_wb_sel;
        data_sel_p0 <= wb_data_sel;
        reg_en_p0   <= wb_reg_en;
      end
      if (load_m_in) begin
        dm_p1       <= DM;
        alu_p1      <= ALU_ea;
        ra_p1       <= ra;
        wb_sel_p1   <= wb_wb_sel;
        data_sel_p1 <= wb_data_sel;
        reg_en_p1   <= wb_reg_en;
      end else if (load_m_skid) begin
        dm_p1       <= dm_p0;
        alu_p1      <= alu_p0;
        ra_p1       <= ra_p0;
        wb_sel_p1   <= wb_sel_p0;
        data_sel_p1 <= data_sel_p0;
        reg_en_p1   <= reg_en_p0;
      end
    end
  end

  // Output and forwarding taps: combinational from the main entry only
  assign in_ready        = in_ready_q;
  assign out_valid       = vld_p1;
  assign DM_out          = dm_p1;
  assign ALU_ea_out      = alu_p1;
  assign ra_out          = ra_p1;
  assign wb_wb_sel_out   = wb_sel_p1;
  assign wb_data_sel_out = data_sel_p1;
  assign wb_reg_en_out   = reg_en_p1 & vld_p1;
  assign fwd_hit         = reg_en_p1 & vld_p1;
  assign fwd_ra          = ra_p1;
  assign fwd_data        = pick_wb_data(data_sel_p1, dm_p1, alu_p1);
  assign occupancy       = count_valid(vld_p1, vld_p0);

endmodule

// File: tb/tb_pipeline_mem_wb.sv
// Directed bench for pipeline_mem_wb: streaming, backpressure, flush, accept+drain
// and asynchronous reset, each checked against hand-computed values.
module tb_pipeline_mem_wb;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] DM;
  logic [7:0] ALU_ea;
  logic [1:0] ra;
  logic       wb_wb_sel;
  logic       wb_data_sel;
  logic       wb_reg_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] DM_out;
  logic [7:0] ALU_ea_out;
  logic [1:0] ra_out;
  logic       wb_wb_sel_out;
  logic       wb_data_sel_out;
  logic       wb_reg_en_out;
  logic       fwd_hit;
  logic [1:0] fwd_ra;
  logic [7:0] fwd_data;
  logic [1:0] occupancy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_mem_wb #(.DATA_W(8), .RA_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .DM(DM), .ALU_ea(ALU_ea), .ra(ra),
    .wb_wb_sel(wb_wb_sel), .wb_data_sel(wb_data_sel), .wb_reg_en(wb_reg_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .DM_out(DM_out), .ALU_ea_out(ALU_ea_out), .ra_out(ra_out),
    .wb_wb_sel_out(wb_wb_sel_out), .wb_data_sel_out(wb_data_sel_out),
    .wb_reg_en_out(wb_reg_en_out),
    .fwd_hit(fwd_hit), .fwd_ra(fwd_ra), .fwd_data(fwd_data),
    .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [7:0] dm_v, input logic [7:0] alu_v,
                       input logic [1:0] ra_v, input logic wsel, input logic dsel,
                       input logic ren);
    in_valid    = v;
    DM          = dm_v;
    ALU_ea      = alu_v;
    ra          = ra_v;
    wb_wb_sel   = wsel;
    wb_data_sel = dsel;
    wb_reg_en   = ren;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    offer(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("reset_in_ready", {7'd0, in_ready}, 8'd1);
    chk("reset_out_valid", {7'd0, out_valid}, 8'd0);
    chk("reset_occupancy", {6'd0, occupancy}, 8'd0);
    rst = 1'b0;

    // Streaming
    out_ready = 1'b1;
    offer(1'b1, 8'hA5, 8'h3C, 2'd2, 1'b1, 1'b1, 1'b1);
    tick();
    offer(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("stream_out_valid", {7'd0, out_valid}, 8'd1);
    chk("stream_dm_out", DM_out, 8'hA5);
    chk("stream_alu_out", ALU_ea_out, 8'h3C);
    chk("stream_fwd_hit", {7'd0, fwd_hit}, 8'd1);
    chk("stream_fwd_ra", {6'd0, fwd_ra}, 8'd2);
    chk("stream_fwd_data", fwd_data, 8'hA5);
    chk("stream_occupancy", {6'd0, occupancy}, 8'd1);
    chk("stream_wb_sel_out", {7'd0, wb_wb_sel_out}, 8'd1);
    chk("stream_reg_en_out", {7'd0, wb_reg_en_out}, 8'd1);
    tick();
    chk("stream_drained_valid", {7'd0, out_valid}, 8'd0);
    chk("stream_drained_hit", {7'd0, fwd_hit}, 8'd0);

    // Backpressure: E1 into M, E2 into S, a third offer is refused
    out_ready = 1'b0;
    offer(1'b1, 8'h00, 8'h11, 2'd1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("bp_occ_one", {6'd0, occupancy}, 8'd1);
    offer(1'b1, 8'h00, 8'h22, 2'd3, 1'b0, 1'b0, 1'b1);
    tick();
    chk("bp_occ_two", {6'd0, occupancy}, 8'd2);
    chk("bp_in_ready_low", {7'd0, in_ready}, 8'd0);
    chk("bp_m_is_e1", ALU_ea_out, 8'h11);
    offer(1'b1, 8'h00, 8'h33, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("bp_stall_occ", {6'd0, occupancy}, 8'd2);
    chk("bp_stall_hold", ALU_ea_out, 8'h11);
    offer(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("bp_second_out", ALU_ea_out, 8'h22);
    chk("bp_second_ra", {6'd0, ra_out}, 8'd3);
    chk("bp_second_fwd", fwd_data, 8'h22);
    chk("bp_occ_after", {6'd0, occupancy}, 8'd1);
    chk("bp_in_ready_back", {7'd0, in_ready}, 8'd1);
    tick();
    chk("bp_empty", {7'd0, out_valid}, 8'd0);

    // Simultaneous accept and drain with S empty
    out_ready = 1'b0;
    offer(1'b1, 8'h00, 8'h44, 2'd1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("ad_m_loaded", ALU_ea_out, 8'h44);
    out_ready = 1'b1;
    offer(1'b1, 8'h55, 8'h7F, 2'd2, 1'b0, 1'b0, 1'b1);
    tick();
    chk("ad_m_new", ALU_ea_out, 8'h7F);
    chk("ad_fwd_data", fwd_data, 8'h7F);
    chk("ad_dm_out", DM_out, 8'h55);
    chk("ad_occ", {6'd0, occupancy}, 8'd1);

    // Flush beats a same-cycle offer; held fields stay put
    out_ready = 1'b0;
    offer(1'b1, 8'h00, 8'h66, 2'd3, 1'b0, 1'b0, 1'b1);
    tick();
    chk("fl_occ_two", {6'd0, occupancy}, 8'd2);
    flush = 1'b1;
    offer(1'b1, 8'h00, 8'h99, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    flush = 1'b0;
    offer(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("fl_occ", {6'd0, occupancy}, 8'd0);
    chk("fl_out_valid", {7'd0, out_valid}, 8'd0);
    chk("fl_reg_en_out", {7'd0, wb_reg_en_out}, 8'd0);
    chk("fl_fwd_hit", {7'd0, fwd_hit}, 8'd0);
    chk("fl_in_ready", {7'd0, in_ready}, 8'd1);
    chk("fl_fields_kept", ALU_ea_out, 8'h7F);
    out_ready = 1'b1;
    tick();
    chk("fl_no_ghost", {7'd0, out_valid}, 8'd0);

    // Asynchronous reset in the middle of a full stall
    out_ready = 1'b0;
    offer(1'b1, 8'h00, 8'h01, 2'd1, 1'b0, 1'b0, 1'b1);
    tick();
    offer(1'b1, 8'h00, 8'h02, 2'd2, 1'b0, 1'b0, 1'b1);
    tick();
    offer(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("ar_occ_two", {6'd0, occupancy}, 8'd2);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", {7'd0, out_valid}, 8'd0);
    chk("ar_occ", {6'd0, occupancy}, 8'd0);
    chk("ar_in_ready", {7'd0, in_ready}, 8'd1);
    chk("ar_alu_out", ALU_ea_out, 8'h00);
    chk("ar_ra_out", {6'd0, ra_out}, 8'd0);
    chk("ar_fwd_data", fwd_data, 8'h00);
    chk("ar_fwd_hit", {7'd0, fwd_hit}, 8'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    offer(1'b1, 8'h00, 8'h5A, 2'd1, 1'b0, 1'b0, 1'b1);
    tick();
    offer(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("ar_first_valid", {7'd0, out_valid}, 8'd1);
    chk("ar_first_alu", ALU_ea_out, 8'h5A);
    chk("ar_first_occ", {6'd0, occupancy}, 8'd1);
    tick();
    chk("ar_end_empty", {6'd0, occupancy}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
